module_mux_display: RTL and testbench

Multi-digit seven-segment display driver with error override. It generalises the 2:1 digit/error selector to N_DIG time-multiplexed digits. A prescaled refresh counter scans the digits and drives active-low anodes, and a synchronised switch replaces every digit with a common error pattern. It sits between the digit encoders and the board display pins.

---
 rtl/module_mux_display_if.sv | 27 ++
 rtl/module_mux_display.sv | 119 +++++++++++
 tb/tb_module_mux_display.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/module_mux_display_if.sv
// rtl/module_mux_display_if.sv - digit/error inputs and segment/anode outputs of the display driver
interface module_mux_display_if #(
  parameter int N_DIG = 4,
  parameter int SEG_W = 7
);
  logic [N_DIG*SEG_W-1:0] siete_seg;
  logic [SEG_W-1:0]       error;
  logic                   swi;
  logic [SEG_W-1:0]       salida_mux;
  logic [N_DIG-1:0]       anodos;

  modport master (
    output siete_seg,
    output error,
    output swi,
    input  salida_mux,
    input  anodos
  );

  modport slave (
    input  siete_seg,
    input  error,
    input  swi,
    output salida_mux,
    output anodos
  );
endinterface

// File: rtl/module_mux_display.sv
// rtl/module_mux_display.sv - N_DIG time-multiplexed seven-segment driver with error override
// Optional blinking of the error pattern: define MODULE_MUX_DISPLAY_BLINK_EN.
module module_mux_display #(
  parameter int N_DIG       = 4,
  parameter int SEG_W       = 7,
  parameter int REFRESH_DIV = 50000,
  parameter int BLINK_TICKS = 64
) (
  input logic                clk,
  input logic                rst_n,
  module_mux_display_if.slave bus
);
  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IDX_W = (N_DIG > 1) ? $clog2(N_DIG) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(N_DIG - 1);

  logic [CNT_W-1:0] cnt;
  logic             tick;
  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] sel;
  logic [N_DIG-1:0] anod_nxt;
  logic [SEG_W-1:0] digit;
  logic [SEG_W-1:0] err_seg;
  logic             swi_meta;
  logic             swi_s;

  assign tick = (cnt == CNT_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx <= '0;
    end else if (tick) begin
      idx <= (idx == IDX_MAX) ? '0 : idx + 1'b1;
    end
  end

  // On a tick the slot being entered is idx, and idx moves on to the following
  // slot; the digit shown is therefore the one just behind idx.
  always_comb begin
    sel = (idx == '0) ? IDX_MAX : idx - 1'b1;
  end

  always_comb begin
    anod_nxt = '1;
    for (int k = 0; k < N_DIG; k++) begin
      anod_nxt[k] = (idx != IDX_W'(k));
    end
  end

  always_comb begin
    digit = '0;
    for (int k = 0; k < N_DIG; k++) begin
      if (sel == IDX_W'(k)) begin
        digit = bus.siete_seg[k*SEG_W +: SEG_W];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      swi_meta <= 1'b0;
      swi_s    <= 1'b0;
    end else begin
      swi_meta <= bus.swi;
      swi_s    <= swi_meta;
    end
  end

`ifdef MODULE_MUX_DISPLAY_BLINK_EN
  localparam int BLK_W = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
  localparam logic [BLK_W-1:0] BLK_MAX = BLK_W'(BLINK_TICKS - 1);

  logic [BLK_W-1:0] blink_cnt;
  logic             blink_hidden;

  // Free-running phase: swi never restarts it, so the blink stays in step
  // with the refresh scan.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_cnt    <= '0;
      blink_hidden <= 1'b0;
    end else if (tick) begin
      if (blink_cnt == BLK_MAX) begin
        blink_cnt    <= '0;
        blink_hidden <= ~blink_hidden;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end
    end
  end

  assign err_seg = blink_hidden ? '0 : bus.error;
`else
  assign err_seg = bus.error;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.salida_mux <= '0;
      bus.anodos     <= '1;
    end else begin
      bus.salida_mux <= swi_s ? err_seg : digit;
      if (tick) begin
        bus.anodos <= anod_nxt;
      end
    end
  end
endmodule

// File: tb/tb_module_mux_display.sv
// tb/tb_module_mux_display.sv - scoreboard bench for module_mux_display (4-digit and 1-digit builds)
module tb_module_mux_display;
  localparam logic [6:0] ERR = 7'b1100110;
`ifdef MODULE_MUX_DISPLAY_BLINK_EN
  localparam bit BLINK = 1'b1;
`else
  localparam bit BLINK = 1'b0;
`endif

  typedef struct {
    int         r;
    int         d;
    logic [3:0] an;
    logic [6:0] sg;
    string      nm;
  } exp_t;

  logic clk;
  logic rst_n;
  int   r;
  int   n_chk;
  int   n_fail;
  exp_t cq1[$];
  exp_t cq2[$];
  exp_t aq[$];
  event chk_ev;

  logic [3:0] an_tab [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
  logic [6:0] seg_tab[4] = '{7'h3F, 7'h06, 7'h5B, 7'h4F};
  logic [6:0] tbl2   [7] = '{7'h11, 7'h22, 7'h7F, 7'h00, 7'h55, 7'h2A, 7'h40};

  module_mux_display_if #(.N_DIG(4), .SEG_W(7)) bus1 ();
  module_mux_display_if #(.N_DIG(1), .SEG_W(7)) bus2 ();

  module_mux_display #(.N_DIG(4), .SEG_W(7), .REFRESH_DIV(4), .BLINK_TICKS(2)) u_dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1.slave)
  );

  module_mux_display #(.N_DIG(1), .SEG_W(7), .REFRESH_DIV(1), .BLINK_TICKS(2)) u_dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus2.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) r <= 0;
    else        r <= r + 1;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, actual r=%0d required end of sequence", r);
    $fatal(1, "timeout");
  end

  task automatic check(input exp_t e, input logic [3:0] a_an, input logic [6:0] a_sg, input int at_r);
    n_chk++;
    if (a_an !== e.an || a_sg !== e.sg) begin
      n_fail++;
      $display("FAIL %s dut%0d r=%0d: anodos=%b salida_mux=%h, required anodos=%b salida_mux=%h",
               e.nm, e.d, at_r, a_an, a_sg, e.an, e.sg);
    end
  endtask

  task automatic missed(input exp_t e, input int at_r);
    n_chk++;
    n_fail++;
    $display("FAIL %s dut%0d: expectation for r=%0d not compared, actual r=%0d", e.nm, e.d, e.r, at_r);
  endtask

  // Cycle monitor: compares whatever expectation is due at this cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      while (cq1.size() > 0 && cq1[0].r <= r) begin
        exp_t e;
        e = cq1.pop_front();
        if (e.r < r) missed(e, r);
        else check(e, bus1.anodos, bus1.salida_mux, r);
      end
      while (cq2.size() > 0 && cq2[0].r <= r) begin
        exp_t e;
        e = cq2.pop_front();
        if (e.r < r) missed(e, r);
        else check(e, {3'b000, bus2.anodos}, bus2.salida_mux, r);
      end
    end
  end

  // Asynchronous-reset monitor.
  initial begin
    forever begin
      @(chk_ev);
      while (aq.size() > 0) begin
        exp_t e;
        e = aq.pop_front();
        if (e.d == 4) check(e, bus1.anodos, bus1.salida_mux, r);
        else          check(e, {3'b000, bus2.anodos}, bus2.salida_mux, r);
      end
    end
  end

  function automatic exp_t mk(input int rr, input int d, input logic [3:0] an, input logic [6:0] sg, input string nm);
    exp_t e;
    e.r = rr; e.d = d; e.an = an; e.sg = sg; e.nm = nm;
    return e;
  endfunction

  function automatic logic [6:0] errv(input int rr);
    if (BLINK && (((rr - 1) / 8) % 2 == 1)) return 7'h00;
    return ERR;
  endfunction

  // First timeline: reset, scan from r=4, swi high 24..42, swi high again from 52.
  function automatic exp_t exp1(input int rr);
    bit err;
    if (rr <= 3) return mk(rr, 4, 4'b1111, 7'h00, "reset_hold");
    if (rr == 4) return mk(rr, 4, 4'b1110, 7'h00, "first_tick");
    err = (rr >= 27 && rr <= 44) || (rr >= 55);
    if (err)
      return mk(rr, 4, an_tab[((rr - 4) / 4) % 4], errv(rr), "override");
    return mk(rr, 4, an_tab[((rr - 4) / 4) % 4], seg_tab[((rr - 5) / 4) % 4], "scan");
  endfunction

  task automatic push_reset();
    aq.push_back(mk(0, 4, 4'b1111, 7'h00, "async_reset"));
    aq.push_back(mk(0, 1, 4'b0001, 7'h00, "async_reset"));
  endtask

  task automatic wait_r(input int t);
    while (r < t) @(negedge clk);
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    rst_n  = 1'b0;
    bus1.siete_seg = '0;
    bus1.error     = ERR;
    bus1.swi       = 1'b0;
    bus2.siete_seg = tbl2[0];
    bus2.error     = 7'h7F;
    bus2.swi       = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    push_reset();
    -> chk_ev;
    #1;
    for (int i = 1; i <= 61; i++) begin
      cq1.push_back(exp1(i));
      cq2.push_back(mk(i, 1, 4'b0000, tbl2[(i - 1 > 6) ? 6 : i - 1], "n1_track"));
    end
    rst_n = 1'b1;

    for (int i = 1; i <= 6; i++) begin
      wait_r(i);
      bus2.siete_seg = tbl2[i];
      if (i == 4) bus1.siete_seg = {7'h4F, 7'h5B, 7'h06, 7'h3F};
    end
    wait_r(24);
    bus1.swi = 1'b1;
    wait_r(42);
    bus1.swi = 1'b0;
    wait_r(52);
    bus1.swi = 1'b1;
    wait_r(61);
    #2;
    rst_n = 1'b0;
    #1;
    push_reset();
    -> chk_ev;
    #1;
    bus1.siete_seg = '0;
    bus1.swi       = 1'b0;

    @(posedge clk);
    @(negedge clk);
    for (int i = 1; i <= 4; i++) begin
      cq1.push_back(mk(i, 4, (i == 4) ? 4'b1110 : 4'b1111, 7'h00, "rerelease"));
      cq2.push_back(mk(i, 1, 4'b0000, tbl2[6], "rerelease"));
    end
    rst_n = 1'b1;
    wait_r(5);
    @(negedge clk);

    if (cq1.size() > 0 || cq2.size() > 0 || aq.size() > 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL drain: pending expectations dut4=%0d dut1=%0d async=%0d, required 0",
               cq1.size(), cq2.size(), aq.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
